// File: rtl/song_reader.sv
// Song ROM sequencer: walks {song, note_index} through the ROM one note per
// note_done, latching note/duration and flagging the end of each song.
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int IDX_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  play,
  input  logic [1:0]            song,
  input  logic                  note_done,
  output logic [IDX_W+1:0]      rom_addr,
  input  logic [2*NOTE_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]     note,
  output logic [NOTE_W-1:0]     duration,
  output logic                  new_note,
  output logic                  song_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    PLAY  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [NOTE_W-1:0] NOTE_ZERO = {NOTE_W{1'b0}};

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] dur_q, dur_d;
  logic              new_note_q, new_note_d;
  logic              song_done_q, song_done_d;

  logic [NOTE_W-1:0] rom_note_s;
  logic [NOTE_W-1:0] rom_dur_s;

  assign rom_note_s = rom_data[2*NOTE_W-1:NOTE_W];
  assign rom_dur_s  = rom_data[NOTE_W-1:0];
  assign rom_addr   = {song, idx_q};

  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

  // Next-state logic; with play low every state simply holds.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    if (restart) begin
      state_d = IDLE;
      idx_d   = IDX_ZERO;
      note_d  = NOTE_ZERO;
      dur_d   = NOTE_ZERO;
    end else if (play) begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = LATCH;
        LATCH: begin
          // A zero duration marks the end of the song.
          if (rom_dur_s != NOTE_ZERO) begin
            note_d     = rom_note_s;
            dur_d      = rom_dur_s;
            new_note_d = 1'b1;
            state_d    = PLAY;
          end else begin
            song_done_d = 1'b1;
            idx_d       = IDX_ZERO;
            state_d     = IDLE;
          end
        end
        PLAY: begin
          if (note_done) begin
            if (idx_q == IDX_LAST) begin
              song_done_d = 1'b1;
              idx_d       = IDX_ZERO;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = FETCH;
            end
          end else begin
            state_d = PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= IDX_ZERO;
      note_q      <= NOTE_ZERO;
      dur_q       <= NOTE_ZERO;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: ROM model, expected-event scoreboard,
// and one task per scenario.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset, restart, play, note_done;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note, duration;
  logic        new_note, song_done;

  typedef struct packed {
    logic       sd;
    logic [5:0] n;
    logic [5:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] rom [0:127];
  int          tests = 0;
  int          fails = 0;
  int          nn_count = 0;
  logic        prev_nn = 1'b0;
  logic        prev_sd = 1'b0;

  song_reader #(.NOTE_W(6), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .restart(restart), .play(play), .song(song),
    .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .duration(duration), .new_note(new_note), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (new_note === 1'b1 && song_done === 1'b1) begin
      tests++; fails++;
      $display("FAIL pulse_overlap new_note and song_done both high at %0t", $time);
    end
    if (new_note === 1'b1) begin
      nn_count++;
      tests++;
      if (prev_nn) begin
        fails++;
        $display("FAIL new_note_width pulse lasted more than one cycle at %0t", $time);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_new_note got note=%0d dur=%0d, none expected", note, duration);
      end else begin
        e = exp_q.pop_front();
        if (e.sd !== 1'b0 || note !== e.n || duration !== e.d) begin
          fails++;
          $display("FAIL sb_new_note got note=%0d dur=%0d, expected sd=%0d note=%0d dur=%0d",
                   note, duration, e.sd, e.n, e.d);
        end
      end
    end
    if (song_done === 1'b1) begin
      tests++;
      if (prev_sd) begin
        fails++;
        $display("FAIL song_done_width pulse lasted more than one cycle at %0t", $time);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_song_done got song_done=1, none expected");
      end else begin
        e = exp_q.pop_front();
        if (e.sd !== 1'b1) begin
          fails++;
          $display("FAIL sb_song_done got song_done, expected new_note note=%0d dur=%0d", e.n, e.d);
        end
      end
    end
    prev_nn = (new_note === 1'b1);
    prev_sd = (song_done === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_note(input int addr);
    exp_t e;
    e.sd = 1'b0;
    e.n  = rom[addr][11:6];
    e.d  = rom[addr][5:0];
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.sd = 1'b1;
    e.n  = 6'd0;
    e.d  = 6'd0;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the next pulse; cycles counts negedges waited.
  task automatic wait_pulse(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (new_note !== 1'b1 && song_done !== 1'b1 && cycles < 12);
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; play = 1'b0; note_done = 1'b0; song = 2'd1;
    repeat (2) tick();
    tests++;
    if ({note, duration, new_note, song_done} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h, expected 0", {note, duration, new_note, song_done});
    end
    tests++;
    if (rom_addr !== 7'd32) begin
      fails++; $display("FAIL reset_addr got %0d, expected 32", rom_addr);
    end
    reset = 1'b0;
    repeat (3) tick();
    tests++;
    if (new_note !== 1'b0 || rom_addr !== 7'd32) begin
      fails++; $display("FAIL idle_wait got nn=%0d addr=%0d, expected 0/32", new_note, rom_addr);
    end
  endtask

  task automatic test_first_note();
    int c;
    play = 1'b1;
    push_note(32);
    wait_pulse(c);
    tests++;
    if (c !== 3) begin
      fails++; $display("FAIL first_latency got %0d cycles, expected 3", c);
    end
    tests++;
    if (note !== 6'd5 || duration !== 6'd10 || rom_addr !== 7'd32) begin
      fails++;
      $display("FAIL first_note got note=%0d dur=%0d addr=%0d, expected 5/10/32", note, duration, rom_addr);
    end
  endtask

  task automatic test_next_note();
    int c;
    note_done = 1'b1;
    push_note(33);
    tick();
    note_done = 1'b0;
    tests++;
    if (rom_addr !== 7'd33) begin
      fails++; $display("FAIL next_addr got %0d, expected 33", rom_addr);
    end
    wait_pulse(c);
    tests++;
    if (c + 1 !== 3) begin
      fails++; $display("FAIL next_latency got %0d cycles, expected 3", c + 1);
    end
  endtask

  task automatic test_end_marker();
    int c;
    logic [11:0] saved;
    saved = rom[34];
    rom[34][5:0] = 6'd0;
    note_done = 1'b1;
    push_done();
    tick();
    note_done = 1'b0;
    tests++;
    if (rom_addr !== 7'd34) begin
      fails++; $display("FAIL end_addr got %0d, expected 34", rom_addr);
    end
    wait_pulse(c);
    play = 1'b0;
    tests++;
    if (c + 1 !== 3 || song_done !== 1'b1 || new_note !== 1'b0) begin
      fails++;
      $display("FAIL end_marker got cycles=%0d sd=%0d nn=%0d, expected 3/1/0", c + 1, song_done, new_note);
    end
    tick();
    tests++;
    if (song_done !== 1'b0 || rom_addr !== 7'd32 || note !== rom[33][11:6] || duration !== rom[33][5:0]) begin
      fails++;
      $display("FAIL end_hold got sd=%0d addr=%0d note=%0d dur=%0d, expected 0/32/%0d/%0d",
               song_done, rom_addr, note, duration, rom[33][11:6], rom[33][5:0]);
    end
    repeat (3) tick();
    rom[34] = saved;
    play = 1'b1;
    push_note(32);
    wait_pulse(c);
    tests++;
    if (c !== 3 || note !== 6'd5) begin
      fails++; $display("FAIL end_idle_restart got cycles=%0d note=%0d, expected 3/5", c, note);
    end
  endtask

  task automatic test_pause();
    int c;
    play = 1'b0;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    repeat (3) tick();
    tests++;
    if (rom_addr !== 7'd32 || note !== 6'd5 || duration !== 6'd10 || new_note !== 1'b0) begin
      fails++;
      $display("FAIL pause_play got addr=%0d note=%0d dur=%0d, expected 32/5/10", rom_addr, note, duration);
    end
    play = 1'b1;
    note_done = 1'b1;
    push_note(33);
    tick();
    note_done = 1'b0;
    wait_pulse(c);
    tests++;
    if (c + 1 !== 3 || rom_addr !== 7'd33) begin
      fails++; $display("FAIL pause_resume got cycles=%0d addr=%0d, expected 3/33", c + 1, rom_addr);
    end
    note_done = 1'b1;
    push_note(34);
    tick();
    note_done = 1'b0;
    tick();
    play = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (new_note !== 1'b0 || note !== rom[33][11:6]) begin
        fails++;
        $display("FAIL pause_latch got nn=%0d note=%0d, expected 0/%0d", new_note, note, rom[33][11:6]);
      end
    end
    play = 1'b1;
    tick();
    tests++;
    if (new_note !== 1'b1) begin
      fails++; $display("FAIL latch_exit got nn=%0d, expected 1", new_note);
    end
    tick();
    tests++;
    if (new_note !== 1'b0) begin
      fails++; $display("FAIL latch_once got nn=%0d, expected 0", new_note);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int nn0;
    play = 1'b0;
    restart = 1'b1;
    song = 2'd2;
    tick();
    restart = 1'b0;
    tests++;
    if (rom_addr !== 7'd64 || note !== 6'd0) begin
      fails++; $display("FAIL song2_start got addr=%0d note=%0d, expected 64/0", rom_addr, note);
    end
    nn0 = nn_count;
    play = 1'b1;
    push_note(64);
    wait_pulse(c);
    tests++;
    if (c !== 3) begin
      fails++; $display("FAIL b2b_first got %0d cycles, expected 3", c);
    end
    for (int i = 1; i < 32; i++) begin
      note_done = 1'b1;
      push_note(64 + i);
      tick();
      note_done = 1'b0;
      wait_pulse(c);
      tests++;
      if (c + 1 !== 3) begin
        fails++; $display("FAIL b2b_latency idx=%0d got %0d cycles, expected 3", i, c + 1);
      end
    end
    note_done = 1'b1;
    push_done();
    tick();
    note_done = 1'b0;
    play = 1'b0;
    tests++;
    if (song_done !== 1'b1 || new_note !== 1'b0 || rom_addr !== 7'd64) begin
      fails++;
      $display("FAIL song_end got sd=%0d nn=%0d addr=%0d, expected 1/0/64", song_done, new_note, rom_addr);
    end
    tests++;
    if (nn_count - nn0 !== 32) begin
      fails++; $display("FAIL note_count got %0d, expected 32", nn_count - nn0);
    end
    tick();
    tests++;
    if (song_done !== 1'b0) begin
      fails++; $display("FAIL song_end_once got sd=%0d, expected 0", song_done);
    end
  endtask

  task automatic test_restart();
    int c;
    restart = 1'b1;
    song = 2'd1;
    tick();
    restart = 1'b0;
    play = 1'b1;
    push_note(32);
    wait_pulse(c);
    note_done = 1'b1;
    push_note(33);
    tick();
    note_done = 1'b0;
    wait_pulse(c);
    tests++;
    if (note !== rom[33][11:6]) begin
      fails++; $display("FAIL restart_setup got note=%0d, expected %0d", note, rom[33][11:6]);
    end
    restart = 1'b1;
    note_done = 1'b1;
    tick();
    restart = 1'b0;
    note_done = 1'b0;
    play = 1'b0;
    tests++;
    if ({note, duration, new_note, song_done} !== 14'd0 || rom_addr !== 7'd32) begin
      fails++;
      $display("FAIL restart_clear got %h addr=%0d, expected 0/32", {note, duration, new_note, song_done}, rom_addr);
    end
    repeat (3) tick();
    tests++;
    if ({note, duration, new_note, song_done} !== 14'd0) begin
      fails++; $display("FAIL restart_quiet got %h, expected 0", {note, duration, new_note, song_done});
    end
  endtask

  task automatic test_async_reset();
    int c;
    play = 1'b1;
    push_note(32);
    wait_pulse(c);
    note_done = 1'b1;
    push_note(33);
    tick();
    note_done = 1'b0;
    wait_pulse(c);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({note, duration, new_note, song_done} !== 14'd0 || rom_addr !== 7'd32) begin
      fails++;
      $display("FAIL async_reset got %h addr=%0d, expected 0/32", {note, duration, new_note, song_done}, rom_addr);
    end
    play = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    tests++;
    if ({note, duration, new_note, song_done} !== 14'd0) begin
      fails++; $display("FAIL post_reset_idle got %h, expected 0", {note, duration, new_note, song_done});
    end
    play = 1'b1;
    push_note(32);
    wait_pulse(c);
    tests++;
    if (c !== 3 || note !== 6'd5) begin
      fails++; $display("FAIL post_reset_play got cycles=%0d note=%0d, expected 3/5", c, note);
    end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      rom[a] = {6'((a * 5) + 3), 6'((a % 62) + 1)};
    end
    rom[32] = {6'd5, 6'd10};
    test_reset();
    test_first_note();
    test_next_note();
    test_end_marker();
    test_pause();
    test_back_to_back();
    test_restart();
    test_async_reset();
    repeat (2) tick();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++; $display("FAIL sb_leftover got %0d pending events, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
